ps_rr_multi: RTL and testbench
==============================

Name: ps_rr_multi

Overview:
- Parametrised round-robin successor to the fixed-priority selector `ps`.
- Grants up to NUM_GNT requests per cycle out of NUM_BITS.
- Priority rotates from a registered pointer, so no requester starves.
- Grants are registered with one-cycle latency and can be frozen by a downstream stall.
- Used as the issue/dispatch select for reservation-station and functional-unit slots.

Parameters:
- NUM_BITS, 16, number of request lines (>=2).
- NUM_GNT, 2, maximum grants per cycle (1..NUM_BITS).
- PTR_W, $clog2(NUM_BITS), pointer width (derived; do not override).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- en  in  1  select enable; when 0, no new grants are made.
- stall  in  1  downstream not ready; grant registers and pointer hold.
- req  in  NUM_BITS  request vector.
- req_up  out  1  combinational: en & |req.
- gnt  out  NUM_GNT x NUM_BITS  registered one-hot grant per output slot; a vector is all-zero if the slot is unused.
- gnt_vld  out  NUM_GNT  registered; gnt_vld[k] = |gnt[k].
- gnt_cnt  out  $clog2(NUM_GNT+1)  registered count of valid grant slots.
- ptr  out  PTR_W  current highest-priority index (debug/verif visibility).

Behaviour:
- Reset (reset==0, asynchronous): gnt=0, gnt_vld=0, gnt_cnt=0, ptr=0. Effect is immediate, mid-cycle included; the first edge after release evaluates normally.
- Search order: ptr, ptr+1, …, NUM_BITS-1, 0, …, ptr-1 (modulo NUM_BITS).
- Slot k receives the (k+1)-th set bit of req in search order.
- Slots are filled in order: gnt_vld is thermometer-shaped (slot k valid implies slots <k valid).
- Each request bit is granted to at most one slot. Grant vectors are pairwise disjoint and each is a subset of req.
- Per rising edge, with reset deasserted:
  - stall=1: gnt, gnt_vld, gnt_cnt and ptr all hold, regardless of en/req.
  - stall=0, en=0: gnt, gnt_vld, gnt_cnt go to 0; ptr holds.
  - stall=0, en=1, req==0: outputs go to 0; ptr holds.
  - stall=0, en=1, req!=0: gnt/gnt_vld/gnt_cnt load the new selection. ptr <= (index of the last granted bit + 1) mod NUM_BITS.
- Latency: req sampled at edge N appears on gnt after edge N (one cycle).
- Pointer wrap: the last granted bit = NUM_BITS-1 gives ptr=0.
- Fewer than NUM_GNT requests: the unused upper slots are zero, and ptr advances past the last granted bit.
- NUM_GNT=1 degenerates to a classic single-grant round-robin arbiter.
- req_up is purely combinational and unaffected by stall or reset state, except that it is gated by en.
- No X propagation: all outputs are defined from reset onward.

Decomposition:
- Shared package (ps_pkg):
  - default NUM_BITS/NUM_GNT localparams;
  - a function for rotate-left/rotate-right of a NUM_BITS vector by PTR_W;
  - a function for the one-hot-to-index encoder.
- Natural sub-module: ps_rot_sel (combinational). It takes req and ptr and produces NUM_GNT disjoint one-hot grants plus the last-granted index, built as rotate, then a cascaded lowest-set-bit pick with masking, then rotate back.
- The top level holds only the registers, the stall/en muxing and the pointer update.

Test Plan (NUM_BITS=16, NUM_GNT=2):
- Reset check: drive reset=0 mid-run while gnt is nonzero → gnt=0, gnt_vld=0, gnt_cnt=0, ptr=0 immediately without a clock edge; after release with req=0 everything stays 0.
- Basic rotation, en=1, stall=0:
  - req=16'h0123, ptr=0 → next cycle gnt[0]=16'h0001, gnt[1]=16'h0002, gnt_cnt=2, ptr=2.
  - Hold req=16'h0123 → gnt[0]=16'h0020, gnt[1]=16'h0100, ptr=9.
- Wrap-around, starting ptr=9, req=16'hf080:
  - first cycle → gnt 16'h1000 / 16'h2000, ptr=14;
  - second cycle → 16'h4000 / 16'h8000, ptr=0;
  - third cycle → 16'h0080 / 16'h1000, ptr=13.
- Partial fill: req=16'h0400, ptr=0 → gnt[0]=16'h0400, gnt[1]=0, gnt_vld=2'b01, gnt_cnt=1, ptr=11. Also check req_up=1.
- Stall/enable:
  - stall=1 while req changes to 16'hffff → gnt and ptr unchanged over 3 cycles.
  - Then stall=0, en=0 → gnt=0, ptr unchanged, req_up=0.
- Property sweep: random req/en/stall for 10k cycles. Check that grants are disjoint, each is a subset of the prior-cycle req, and gnt_vld is thermometer. Check fairness: with req=16'hffff constant, every bit is granted exactly once per 8 cycles.

Source files
------------

// File: rtl/ps_rr_multi_pkg.sv
// Shared defaults and helpers for the ps_rr_multi round-robin multi-grant selector.
// Rotations and encoding use a fixed MAX_BITS container so every instance size can share them.
package ps_rr_multi_pkg;

    localparam int DEF_NUM_BITS = 16;
    localparam int DEF_NUM_GNT  = 2;
    localparam int MAX_BITS     = 64;
    localparam int IDX_W        = 6;

    // Result bit i comes from v[(i+sh) mod n], so the result's bit 0 is v[sh].
    function automatic logic [MAX_BITS-1:0] rot_right(input logic [MAX_BITS-1:0] v,
                                                      input logic [IDX_W-1:0]    sh,
                                                      input int                  n);
        logic [MAX_BITS-1:0] r;
        logic [IDX_W-1:0]    idx;
        r   = {MAX_BITS{1'b0}};
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < MAX_BITS; i++) begin
            idx  = IDX_W'((i + int'(sh)) % n);
            r[i] = (i < n) ? v[idx] : 1'b0;
        end
        return r;
    endfunction

    function automatic logic [MAX_BITS-1:0] rot_left(input logic [MAX_BITS-1:0] v,
                                                     input logic [IDX_W-1:0]    sh,
                                                     input int                  n);
        logic [MAX_BITS-1:0] r;
        logic [IDX_W-1:0]    idx;
        r   = {MAX_BITS{1'b0}};
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < MAX_BITS; i++) begin
            idx  = IDX_W'((i - int'(sh) + n) % n);
            r[i] = (i < n) ? v[idx] : 1'b0;
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_BITS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < MAX_BITS; i++) begin
            idx = idx | (v[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
        return idx;
    endfunction

endpackage

// File: rtl/ps_rr_multi_if.sv
// Request/grant bundle between a requester array and the ps_rr_multi selector.
interface ps_rr_multi_if #(
    parameter int NUM_BITS = 16,
    parameter int NUM_GNT  = 2,
    parameter int PTR_W    = $clog2(NUM_BITS)
);
    localparam int CNT_W = $clog2(NUM_GNT + 1);

    logic                               en;
    logic                               stall;
    logic [NUM_BITS-1:0]                req;
    logic                               req_up;
    logic [NUM_GNT-1:0][NUM_BITS-1:0]   gnt;
    logic [NUM_GNT-1:0]                 gnt_vld;
    logic [CNT_W-1:0]                   gnt_cnt;
    logic [PTR_W-1:0]                   ptr;

    modport master (output en, stall, req, input req_up, gnt, gnt_vld, gnt_cnt, ptr);
    modport slave  (input en, stall, req, output req_up, gnt, gnt_vld, gnt_cnt, ptr);
endinterface

// File: rtl/ps_rr_multi_rot_sel.sv
// Combinational multi-grant picker: rotate req so ptr sits at bit 0, peel off the
// lowest set bits one slot at a time, then rotate each pick back.
module ps_rr_multi_rot_sel
    import ps_rr_multi_pkg::*;
#(
    parameter int NUM_BITS = DEF_NUM_BITS,
    parameter int NUM_GNT  = DEF_NUM_GNT,
    parameter int PTR_W    = $clog2(NUM_BITS)
) (
    input  logic [NUM_BITS-1:0]              req,
    input  logic [PTR_W-1:0]                 ptr,
    output logic [NUM_GNT-1:0][NUM_BITS-1:0] gnt,
    output logic [NUM_GNT-1:0]               vld,
    output logic [PTR_W-1:0]                 last_idx
);

    logic [NUM_BITS-1:0]              rot_req_s;
    logic [NUM_BITS-1:0]              rem_s;
    logic [NUM_GNT-1:0][NUM_BITS-1:0] pick_s;
    logic [PTR_W-1:0]                 last_rot_s;

    // Align the search start with bit 0.
    always_comb begin
        rot_req_s = NUM_BITS'(rot_right(MAX_BITS'(req), IDX_W'(ptr), NUM_BITS));
    end

    // Cascaded lowest-set-bit pick; each slot masks out what earlier slots took.
    always_comb begin
        rem_s      = rot_req_s;
        pick_s     = '0;
        vld        = '0;
        last_rot_s = '0;
        for (int k = 0; k < NUM_GNT; k++) begin
            pick_s[k]  = rem_s & (~rem_s + NUM_BITS'(1));
            rem_s      = rem_s & ~pick_s[k];
            vld[k]     = |pick_s[k];
            last_rot_s = vld[k] ? PTR_W'(onehot_to_idx(MAX_BITS'(pick_s[k]))) : last_rot_s;
        end
    end

    // Undo the rotation for the grants and the last-granted position.
    always_comb begin
        gnt = '0;
        for (int k = 0; k < NUM_GNT; k++) begin
            gnt[k] = NUM_BITS'(rot_left(MAX_BITS'(pick_s[k]), IDX_W'(ptr), NUM_BITS));
        end
        last_idx = PTR_W'((int'(last_rot_s) + int'(ptr)) % NUM_BITS);
    end

endmodule

// File: rtl/ps_rr_multi.sv
// Round-robin issue select granting up to NUM_GNT of NUM_BITS requests per cycle,
// with registered grants, stall freeze and a rotating priority pointer.
module ps_rr_multi
    import ps_rr_multi_pkg::*;
#(
    parameter int NUM_BITS = DEF_NUM_BITS,
    parameter int NUM_GNT  = DEF_NUM_GNT,
    parameter int PTR_W    = $clog2(NUM_BITS)
) (
    input  logic          clock,
    input  logic          reset,
    ps_rr_multi_if.slave  bus
);

    localparam int CNT_W = $clog2(NUM_GNT + 1);

    logic [NUM_GNT-1:0][NUM_BITS-1:0] sel_gnt_s;
    logic [NUM_GNT-1:0]               sel_vld_s;
    logic [PTR_W-1:0]                 sel_last_s;
    logic [CNT_W-1:0]                 sel_cnt_s;

    logic [NUM_GNT-1:0][NUM_BITS-1:0] gnt_s;
    logic [NUM_GNT-1:0]               vld_s;
    logic [CNT_W-1:0]                 cnt_s;
    logic [PTR_W-1:0]                 ptr_s;

    logic [NUM_GNT-1:0][NUM_BITS-1:0] gnt_r;
    logic [NUM_GNT-1:0]               vld_r;
    logic [CNT_W-1:0]                 cnt_r;
    logic [PTR_W-1:0]                 ptr_r;

    ps_rr_multi_rot_sel #(
        .NUM_BITS (NUM_BITS),
        .NUM_GNT  (NUM_GNT),
        .PTR_W    (PTR_W)
    ) u_rot_sel (
        .req      (bus.req),
        .ptr      (ptr_r),
        .gnt      (sel_gnt_s),
        .vld      (sel_vld_s),
        .last_idx (sel_last_s)
    );

    // Number of filled slots in the fresh selection.
    always_comb begin
        sel_cnt_s = '0;
        for (int k = 0; k < NUM_GNT; k++) begin
            sel_cnt_s = sel_cnt_s + CNT_W'(sel_vld_s[k]);
        end
    end

    // Stall freezes everything; idle or disabled clears grants but keeps the pointer.
    always_comb begin
        gnt_s = gnt_r;
        vld_s = vld_r;
        cnt_s = cnt_r;
        ptr_s = ptr_r;
        if (bus.stall) begin
            gnt_s = gnt_r;
            ptr_s = ptr_r;
        end else if (!bus.en || (bus.req == '0)) begin
            gnt_s = '0;
            vld_s = '0;
            cnt_s = '0;
        end else begin
            gnt_s = sel_gnt_s;
            vld_s = sel_vld_s;
            cnt_s = sel_cnt_s;
            ptr_s = PTR_W'((int'(sel_last_s) + 1) % NUM_BITS);
        end
    end

    // Grant and pointer registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt_r <= '0;
            vld_r <= '0;
            cnt_r <= '0;
            ptr_r <= '0;
        end else begin
            gnt_r <= gnt_s;
            vld_r <= vld_s;
            cnt_r <= cnt_s;
            ptr_r <= ptr_s;
        end
    end

    assign bus.req_up  = bus.en & (|bus.req);
    assign bus.gnt     = gnt_r;
    assign bus.gnt_vld = vld_r;
    assign bus.gnt_cnt = cnt_r;
    assign bus.ptr     = ptr_r;

endmodule

// File: tb/tb_ps_rr_multi.sv
// Bench for ps_rr_multi (16 requests, 2 grants): search-order model, per-cycle compare,
// directed literal checks, fairness window and a random property sweep.
module tb_ps_rr_multi;

    localparam int NB = 16;
    localparam int NG = 2;
    localparam int PW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ps_rr_multi_if #(.NUM_BITS(NB), .NUM_GNT(NG)) bus ();

    ps_rr_multi #(.NUM_BITS(NB), .NUM_GNT(NG)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [NG-1:0][NB-1:0] g;
        logic [PW-1:0]         p;
    } sel_t;

    // Walk requests starting at p; hand the next set bit to the next free slot.
    function automatic sel_t model_sel(input logic [NB-1:0] r, input logic [PW-1:0] p);
        sel_t          s;
        int            filled;
        logic [PW-1:0] idx;
        s      = '0;
        s.p    = p;
        filled = 0;
        for (int j = 0; j < NB; j++) begin
            idx = PW'((int'(p) + j) % NB);
            if (r[idx] && filled < NG) begin
                s.g[filled] = NB'(1) << idx;
                s.p         = PW'((int'(idx) + 1) % NB);
                filled++;
            end
        end
        return s;
    endfunction

    logic [NG-1:0][NB-1:0] m_gnt;
    logic [PW-1:0]         m_ptr;
    logic [NB-1:0]         m_src;
    sel_t                  m_next;

    assign m_next = model_sel(bus.req, m_ptr);

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_gnt <= '0;
            m_ptr <= '0;
            m_src <= '0;
        end else if (bus.stall) begin
            m_gnt <= m_gnt;
        end else if (!bus.en || bus.req == '0) begin
            m_gnt <= '0;
            m_src <= bus.req;
        end else begin
            m_gnt <= m_next.g;
            m_ptr <= m_next.p;
            m_src <= bus.req;
        end
    end

    always @(negedge clock) begin
        if (chk_on && reset) begin
            int nvalid;
            nvalid = 0;
            for (int k = 0; k < NG; k++) begin
                chk($sformatf("gnt[%0d]", k), 32'(bus.gnt[k]), 32'(m_gnt[k]));
                chk($sformatf("gnt_vld[%0d]", k), 32'(bus.gnt_vld[k]), 32'(|m_gnt[k]));
                chk($sformatf("subset[%0d]", k), 32'(bus.gnt[k] & ~m_src), 32'd0);
                if (m_gnt[k] != '0) nvalid++;
            end
            chk("gnt_cnt", 32'(bus.gnt_cnt), 32'(nvalid));
            chk("ptr", 32'(bus.ptr), 32'(m_ptr));
            chk("req_up", 32'(bus.req_up), 32'(bus.en && (bus.req != '0)));
            chk("disjoint", 32'(bus.gnt[0] & bus.gnt[1]), 32'd0);
            chk("thermo", 32'(bus.gnt_vld[1] & ~bus.gnt_vld[0]), 32'd0);
        end
    end

    // Positioned at a negedge: drive inputs, let one posedge pass, stop at the next negedge.
    task automatic step(input logic e, input logic s, input logic [NB-1:0] r);
        #1;
        bus.en    = e;
        bus.stall = s;
        bus.req   = r;
        @(negedge clock);
    endtask

    task automatic expect_out(input string tag, input logic [NB-1:0] g0, input logic [NB-1:0] g1,
                              input logic [1:0] vld, input logic [1:0] cnt, input logic [PW-1:0] p);
        chk({tag, ".g0"}, 32'(bus.gnt[0]), 32'(g0));
        chk({tag, ".g1"}, 32'(bus.gnt[1]), 32'(g1));
        chk({tag, ".vld"}, 32'(bus.gnt_vld), 32'(vld));
        chk({tag, ".cnt"}, 32'(bus.gnt_cnt), 32'(cnt));
        chk({tag, ".ptr"}, 32'(bus.ptr), 32'(p));
    endtask

    int hits [NB];

    initial begin
        bus.en    = 1'b0;
        bus.stall = 1'b0;
        bus.req   = '0;
        #1 reset  = 1'b0;
        chk_on    = 1'b1;
        @(negedge clock);
        expect_out("por", 16'h0000, 16'h0000, 2'b00, 2'd0, 4'd0);
        #1 reset = 1'b1;
        @(negedge clock);

        step(1'b1, 1'b0, 16'h0123);
        expect_out("rot1", 16'h0001, 16'h0002, 2'b11, 2'd2, 4'd2);
        step(1'b1, 1'b0, 16'h0123);
        expect_out("rot2", 16'h0020, 16'h0100, 2'b11, 2'd2, 4'd9);

        step(1'b1, 1'b0, 16'hf080);
        expect_out("wrap1", 16'h1000, 16'h2000, 2'b11, 2'd2, 4'd14);
        step(1'b1, 1'b0, 16'hf080);
        expect_out("wrap2", 16'h4000, 16'h8000, 2'b11, 2'd2, 4'd0);
        step(1'b1, 1'b0, 16'hf080);
        expect_out("wrap3", 16'h0080, 16'h1000, 2'b11, 2'd2, 4'd13);

        step(1'b1, 1'b0, 16'h8000);
        expect_out("to0", 16'h8000, 16'h0000, 2'b01, 2'd1, 4'd0);
        step(1'b1, 1'b0, 16'h0400);
        expect_out("part", 16'h0400, 16'h0000, 2'b01, 2'd1, 4'd11);
        chk("part.req_up", 32'(bus.req_up), 32'd1);

        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 16'hffff);
            expect_out("stall", 16'h0400, 16'h0000, 2'b01, 2'd1, 4'd11);
        end
        step(1'b0, 1'b0, 16'hffff);
        expect_out("dis", 16'h0000, 16'h0000, 2'b00, 2'd0, 4'd11);
        chk("dis.req_up", 32'(bus.req_up), 32'd0);

        step(1'b1, 1'b0, 16'h0123);
        expect_out("pre_rst", 16'h0001, 16'h0002, 2'b11, 2'd2, 4'd2);
        #2 reset = 1'b0;
        #1;
        expect_out("async_rst", 16'h0000, 16'h0000, 2'b00, 2'd0, 4'd0);
        bus.req = '0;
        #1 reset = 1'b1;
        @(negedge clock);
        expect_out("post_rst1", 16'h0000, 16'h0000, 2'b00, 2'd0, 4'd0);
        @(negedge clock);
        expect_out("post_rst2", 16'h0000, 16'h0000, 2'b00, 2'd0, 4'd0);

        for (int b = 0; b < NB; b++) hits[b] = 0;
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 1'b0, 16'hffff);
            for (int b = 0; b < NB; b++) begin
                hits[b] += int'(bus.gnt[0][b]) + int'(bus.gnt[1][b]);
            end
        end
        for (int b = 0; b < NB; b++) chk($sformatf("fair[%0d]", b), 32'(hits[b]), 32'd1);
        chk("fair.ptr", 32'(bus.ptr), 32'd0);

        for (int c = 0; c < 10000; c++) begin
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0), NB'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
